// File: rtl/pam4_tx_mapper.sv
// -----------------------------------------------------------------------------
// pam4_tx_mapper
//
// Transmit-side PAM4 symbol mapper and zero-stuffing upsampler.
//
// Each 2-bit Gray-coded symbol accepted on the valid/ready handshake becomes
// one signed amplitude sample. That sample is followed by OS-1 zero samples,
// giving a stream ready for the pulse-shaping FIR. The output format
// S(NB_OUT, NBF_OUT) matches the sample input of the receive-side FIR.
//
// Gray mapping, in units of 2^NBF_OUT:
//   00 -> -3,  01 -> -1,  11 -> +1,  10 -> +3
//
// Parameters:
//   NB_OUT   output sample width (signed)
//   NBF_OUT  output fractional bits
//   OS       oversampling factor (>= 2)
//
// Ports:
//   i_clock      single clock, rising edge
//   i_reset      asynchronous, active-low reset
//   i_enable     global enable; low freezes every register
//   i_valid      upstream symbol valid
//   i_gray       Gray-coded symbol
//   o_ready      combinational; a symbol is taken when i_valid && o_ready
//   o_sample     registered output sample
//   o_valid      registered; o_sample belongs to the live stream
//   o_underflow  sticky; the stream ran dry at a symbol boundary
//
// Build option:
//   PAM4_TX_PRBS_EN  when defined, an internal PRBS9 (x^9 + x^5 + 1, seed
//                    9'h1FF) supplies the symbols in place of i_gray, and
//                    i_valid is treated as always high. In that build
//                    o_underflow never sets. The ports are the same in
//                    both builds.
// -----------------------------------------------------------------------------
module pam4_tx_mapper #(
    parameter int NB_OUT  = 18,
    parameter int NBF_OUT = 15,
    parameter int OS      = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic [1:0]               i_gray,
    output logic                     o_ready,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic                     o_valid,
    output logic                     o_underflow
);

    // Phase counter sizing. OS >= 2 always gives a width of at least 1; the
    // guard only keeps the width legal if the module is ever elaborated with
    // an out-of-range OS.
    localparam int PHASE_W = (OS > 1) ? $clog2(OS) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OS - 1);

    // Amplitude levels: +-1 and +-3 scaled by 2^NBF_OUT.
    localparam int LVL_ONE = 1 << NBF_OUT;
    localparam logic signed [NB_OUT-1:0] LVL_M3 = NB_OUT'(-3 * LVL_ONE);
    localparam logic signed [NB_OUT-1:0] LVL_M1 = NB_OUT'(-LVL_ONE);
    localparam logic signed [NB_OUT-1:0] LVL_P1 = NB_OUT'(LVL_ONE);
    localparam logic signed [NB_OUT-1:0] LVL_P3 = NB_OUT'(3 * LVL_ONE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_q,     state_d;
    logic [PHASE_W-1:0]         phase_q,     phase_d;
    logic signed [NB_OUT-1:0]   sample_q,    sample_d;
    logic                       valid_q,     valid_d;
    logic                       underflow_q, underflow_d;

    // Symbol source after the build option has been applied.
    logic [1:0] sym_gray;
    logic       sym_valid;
    logic       accept;

    // -------------------------------------------------------------------------
    // Symbol source
    // -------------------------------------------------------------------------
`ifdef PAM4_TX_PRBS_EN
    // Fibonacci PRBS9: each new bit is s[8] ^ s[4], and it is shifted in at
    // the LSB. Two bits are consumed per accepted symbol. The second bit taps
    // the register as it stands after the first shift, so it is s[7] ^ s[3].
    logic [8:0] prbs_q, prbs_d;
    logic       prbs_b0;
    logic       prbs_b1;

    // i_gray and i_valid are deliberately ignored in this build.
    logic unused_inputs;
    assign unused_inputs = ^{i_gray, i_valid};

    always_comb begin
        prbs_b0   = prbs_q[8] ^ prbs_q[4];
        prbs_b1   = prbs_q[7] ^ prbs_q[3];
        // The first generated bit is the symbol MSB.
        sym_gray  = {prbs_b0, prbs_b1};
        sym_valid = 1'b1;
    end

    always_comb begin
        prbs_d = prbs_q;
        if (accept) begin
            prbs_d = {prbs_q[6:0], prbs_b0, prbs_b1};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            prbs_q <= 9'h1FF;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`else
    always_comb begin
        sym_gray  = i_gray;
        sym_valid = i_valid;
    end
`endif

    // -------------------------------------------------------------------------
    // Gray to amplitude
    // -------------------------------------------------------------------------
    function automatic logic signed [NB_OUT-1:0] gray_to_level(input logic [1:0] g);
        logic signed [NB_OUT-1:0] lvl;
        case (g)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;  // 2'b10
        endcase
        return lvl;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A new symbol can be taken whenever the mapper is idle, or on the last
    // zero slot of the current symbol. Taking one on that last slot keeps a
    // sustained stream back-to-back with no gap. While disabled, nothing is
    // accepted.
    always_comb begin
        o_ready = i_enable && ((state_q == ST_IDLE) || (phase_q == PHASE_LAST));
        accept  = o_ready && sym_valid;
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Holding is the default, which also covers i_enable low.
        state_d     = state_q;
        phase_d     = phase_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        underflow_d = underflow_q;

        if (i_enable) begin
            if (accept) begin
                // Idle start or back-to-back continuation: the level sample
                // occupies phase 0.
                state_d  = ST_RUN;
                phase_d  = '0;
                sample_d = gray_to_level(sym_gray);
                valid_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sample_d = '0;
                        valid_d  = 1'b0;
                    end
                    ST_RUN: begin
                        if (phase_q != PHASE_LAST) begin
                            // Zero-stuffing slots.
                            phase_d  = phase_q + 1'b1;
                            sample_d = '0;
                            valid_d  = 1'b1;
                        end else begin
                            // The symbol period ended with nothing waiting.
                            // The live stream has been broken, so flag it.
                            state_d     = ST_IDLE;
                            phase_d     = '0;
                            sample_d    = '0;
                            valid_d     = 1'b0;
                            underflow_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        phase_d  = '0;
                        sample_d = '0;
                        valid_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_sample    = sample_q;
    assign o_valid     = valid_q;
    assign o_underflow = underflow_q;

endmodule

// File: doc/pam4_tx_mapper.md
# pam4_tx_mapper

Transmit-side PAM4 symbol mapper and zero-stuffing upsampler. It accepts 2-bit Gray-coded symbols over a valid/ready handshake and maps each one to a signed fixed-point amplitude. It then emits that amplitude followed by OS−1 zero samples, feeding the pulse-shaping FIR. It is the transmit counterpart of the receive-side FIR + `slicer_pam4` chain: its output format matches the FIR sample input.

## Interface
- `NB_OUT`, 18, output sample width (signed).
- `NBF_OUT`, 15, output fractional bits; format S(NB_OUT, NBF_OUT).
- `OS`, 4, oversampling factor, ≥2; one symbol sample per OS output samples.
- `i_clock` input 1 — single clock, all logic on rising edge.
- `i_reset` input 1 — asynchronous, active-low reset.
- `i_enable` input 1 — global enable; low freezes all state.
- `i_valid` input 1 — upstream symbol valid.
- `i_gray` input 2 — Gray-coded symbol.
- `o_ready` output 1 — symbol accepted this cycle when `i_valid && o_ready`; combinational.
- `o_sample` output NB_OUT — registered output sample.
- `o_valid` output 1 — registered; `o_sample` is part of the live stream.
- `o_underflow` output 1 — sticky; set when the stream starves mid-run.

## Operation
- Gray mapping, scaled by 2^NBF_OUT:
  - 00 → −3
  - 01 → −1
  - 11 → +1
  - 10 → +3
- With default widths the four levels are 18'h28000, 18'h38000, 18'h08000 and 18'h18000.
- State machine: IDLE, RUN. Phase counter `phase`, width $clog2(OS), range 0..OS−1.
- `o_ready = i_enable && (state==IDLE || phase==OS−1)`.
- IDLE, accept (enabled, `i_valid`):
  - `o_sample` ← level; `o_valid` ← 1; `phase` ← 0; go to RUN.
- IDLE, no accept:
  - `o_sample` ← 0; `o_valid` ← 0; stay IDLE.
- RUN, `phase < OS−1`:
  - `o_sample` ← 0; `o_valid` ← 1; `phase` ← `phase`+1.
- RUN, `phase == OS−1`, accept:
  - Same as IDLE accept. The stream is back-to-back with no gap.
- RUN, `phase == OS−1`, no `i_valid`:
  - `o_sample` ← 0; `o_valid` ← 0; go to IDLE; `o_underflow` ← 1.
- `i_enable` low:
  - All registers hold, including `o_sample` and `o_valid`.
  - `o_ready` is 0; `i_valid` is ignored.
- `o_underflow` clears only on reset. The first IDLE→RUN start never sets it.

## Timing
- Reset (async assert, sync-to-clock deassert by system) forces:
  - `o_sample` = 0
  - `o_valid` = 0
  - `o_underflow` = 0
  - state = IDLE, `phase` = 0
  - PRBS register = 9'h1FF
- Latency: symbol accepted at edge n → its level on `o_sample` after edge n. The OS−1 zeros follow on edges n+1..n+OS−1.
- Sustained throughput: one symbol per OS enabled cycles. `o_ready` pulses exactly once per OS cycles while `i_valid` stays high.
- Enable deasserted mid-burst: the phase sequence resumes where it stopped, and no sample is dropped or duplicated.
- Reset mid-burst: the held symbol is discarded, and the next accept restarts at phase 0.

## Configuration
- `PAM4_TX_PRBS_EN` defined:
  - An internal PRBS9 source (x^9+x^5+1, seed 9'h1FF) replaces `i_gray`, and `i_valid` is treated as 1.
  - On each accept, the PRBS advances 2 bits; the symbol is {first bit, second bit}, first bit = MSB.
  - `o_underflow` never sets.
- `PAM4_TX_PRBS_EN` undefined:
  - `i_gray` and `i_valid` are used as described above.
- Ports are identical in both builds.

## Test plan
- Reset then enable, `i_valid`=1, `i_gray`=2'b10 constant, OS=4 → `o_sample` = 18'h18000,0,0,0 repeating. `o_valid` stays 1 and `o_ready` is high every 4th cycle.
- Symbols 00,01,11,10 back-to-back → level samples 18'h28000, 18'h38000, 18'h08000, 18'h18000 at cycles 0, 4, 8, 12, with zeros between.
- Drop `i_valid` before the second symbol → `o_valid` falls at cycle 4, `o_underflow` goes to 1 and stays 1. Reassert `i_valid` → restart with the level sample immediately.
- Deassert `i_enable` for 3 cycles at phase 2 → `o_sample`/`o_valid` hold. The remaining zero and the next symbol then appear with the period preserved.
- Assert `i_reset` low at phase 1 of a burst → all outputs are 0 immediately (asynchronously). After release, the first accepted symbol appears at phase 0.
- With `PAM4_TX_PRBS_EN`, enabled for 511×4 cycles → the recovered bit stream matches the PRBS9 reference model and repeats after 511 symbols of 2 bits.
